// File: rtl/wb_dual_master_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: bus type codes,
// arbiter state encoding and default timeout sizing.
package wb_dual_master_arbiter_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   localparam int DEFAULT_TIMEOUT = 255;
   localparam int DEFAULT_TO_W    = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_OWN0 = 2'b01,
      ST_OWN1 = 2'b10
   } arb_state_e;

   function automatic arb_state_e own_state(input logic idx);
      return idx ? ST_OWN1 : ST_OWN0;
   endfunction

endpackage

// File: rtl/wb_dual_master_arbiter_if.sv
// Bus bundle for the arbiter: packed two-master Wishbone side plus the
// single downstream slave port.
interface wb_dual_master_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [1:0]          m_cyc_i;
   logic [1:0]          m_stb_i;
   logic [1:0]          m_we_i;
   logic [2*AW-1:0]     m_adr_i;
   logic [2*DW/8-1:0]   m_sel_i;
   logic [2*DW-1:0]     m_dat_i;
   logic [5:0]          m_cti_i;
   logic [3:0]          m_bte_i;
   logic [1:0]          m_ack_o;
   logic [1:0]          m_err_o;
   logic [1:0]          m_rty_o;
   logic [2*DW-1:0]     m_dat_o;

   logic                s_cyc_o;
   logic                s_stb_o;
   logic                s_we_o;
   logic [AW-1:0]       s_adr_o;
   logic [DW/8-1:0]     s_sel_o;
   logic [DW-1:0]       s_dat_o;
   logic [2:0]          s_cti_o;
   logic [1:0]          s_bte_o;
   logic                s_ack_i;
   logic                s_err_i;
   logic                s_rty_i;
   logic [DW-1:0]       s_dat_i;

   // The arbiter is the bus master toward memory.
   modport master (
      input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i, m_cti_i, m_bte_i,
      output m_ack_o, m_err_o, m_rty_o, m_dat_o,
      output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o, s_cti_o, s_bte_o,
      input  s_ack_i, s_err_i, s_rty_i, s_dat_i
   );

   modport slave (
      output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i, m_cti_i, m_bte_i,
      input  m_ack_o, m_err_o, m_rty_o, m_dat_o,
      input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o, s_cti_o, s_bte_o,
      output s_ack_i, s_err_i, s_rty_i, s_dat_i
   );

endinterface

// File: rtl/wb_dual_master_arbiter_timeout.sv
// Watchdog for an unanswered strobe: counts stalled strobe cycles and fires
// once the owner has waited TIMEOUT cycles without any slave response.
module wb_timeout_counter #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic stb_req,
   input  logic resp,
   input  logic clear,
   output logic to_fire
);

   logic [TO_W-1:0] count_reg;
   logic [TO_W-1:0] count_next;

   // A response in the final cycle still wins over the forced error.
   assign to_fire = stb_req & ~resp & (count_reg == TO_W'(TIMEOUT - 1));

   always_comb begin
      count_next = count_reg;
      if (clear || resp || to_fire) begin
         count_next = '0;
      end else if (stb_req) begin
         count_next = count_reg + TO_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/wb_dual_master_arbiter.sv
// Two-master Wishbone arbiter: grants a whole cyc to one master, alternates
// under contention and forces a bus error on a stalled strobe.
module wb_dual_master_arbiter
   import wb_dual_master_arbiter_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int TO_W    = DEFAULT_TO_W
) (
   input  logic                        clk,
   input  logic                        rst,
   wb_dual_master_arbiter_if.master    bus,
   output logic [1:0]                  grant_o,
   output logic                        timeout_o
);

   arb_state_e state_reg, state_next;
   logic       last_owner_reg, last_owner_next;
   logic       own_idx;
   logic       active;
   logic       stb_req;
   logic       resp;
   logic       to_clear;
   logic       to_fire;

   logic [AW-1:0]   adr_arr [2];
   logic [DW/8-1:0] sel_arr [2];
   logic [DW-1:0]   dat_arr [2];
   logic [2:0]      cti_arr [2];
   logic [1:0]      bte_arr [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_unpack
         assign adr_arr[gi] = bus.m_adr_i[gi*AW +: AW];
         assign sel_arr[gi] = bus.m_sel_i[gi*(DW/8) +: DW/8];
         assign dat_arr[gi] = bus.m_dat_i[gi*DW +: DW];
         assign cti_arr[gi] = bus.m_cti_i[gi*3 +: 3];
         assign bte_arr[gi] = bus.m_bte_i[gi*2 +: 2];
      end
   endgenerate

   assign own_idx = (state_reg == ST_OWN1);
   assign active  = (state_reg != ST_IDLE);

   always_comb begin
      state_next      = state_reg;
      last_owner_next = last_owner_reg;
      case (state_reg)
         ST_IDLE: begin
            if (bus.m_cyc_i[0] && bus.m_cyc_i[1]) begin
               state_next = own_state(~last_owner_reg);
            end else if (bus.m_cyc_i[0]) begin
               state_next = ST_OWN0;
            end else if (bus.m_cyc_i[1]) begin
               state_next = ST_OWN1;
            end
         end
         ST_OWN0, ST_OWN1: begin
            // Ownership ends only when cyc drops, so bursts stay intact.
            if (!bus.m_cyc_i[own_idx]) begin
               last_owner_next = own_idx;
               state_next      = bus.m_cyc_i[~own_idx] ? own_state(~own_idx) : ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         last_owner_reg <= 1'b1;
      end else begin
         state_reg      <= state_next;
         last_owner_reg <= last_owner_next;
      end
   end

   assign stb_req  = active & bus.m_stb_i[own_idx] & bus.m_cyc_i[own_idx];
   assign resp     = active & (bus.s_ack_i | bus.s_err_i | bus.s_rty_i);
   assign to_clear = ~active | (state_next != state_reg);

   wb_timeout_counter #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .stb_req (stb_req),
      .resp    (resp),
      .clear   (to_clear),
      .to_fire (to_fire)
   );

   always_comb begin
      grant_o = 2'b00;
      case (state_reg)
         ST_OWN0: grant_o = 2'b01;
         ST_OWN1: grant_o = 2'b10;
         default: grant_o = 2'b00;
      endcase
   end

   always_comb begin
      bus.s_cyc_o = 1'b0;
      bus.s_stb_o = 1'b0;
      bus.s_we_o  = 1'b0;
      bus.s_adr_o = '0;
      bus.s_sel_o = '0;
      bus.s_dat_o = '0;
      bus.s_cti_o = '0;
      bus.s_bte_o = '0;
      if (active) begin
         bus.s_cyc_o = bus.m_cyc_i[own_idx];
         bus.s_stb_o = stb_req & ~to_fire;
         bus.s_we_o  = bus.m_we_i[own_idx];
         bus.s_adr_o = adr_arr[own_idx];
         bus.s_sel_o = sel_arr[own_idx];
         bus.s_dat_o = dat_arr[own_idx];
         bus.s_cti_o = cti_arr[own_idx];
         bus.s_bte_o = bte_arr[own_idx];
      end
   end

   // grant_o is 00 in IDLE, which also drops any stray slave response.
   assign bus.m_ack_o = grant_o & {2{bus.s_ack_i}};
   assign bus.m_err_o = grant_o & {2{bus.s_err_i | to_fire}};
   assign bus.m_rty_o = grant_o & {2{bus.s_rty_i}};
   assign bus.m_dat_o = {bus.s_dat_i, bus.s_dat_i};
   assign timeout_o   = to_fire;

endmodule
